// File: rtl/arb_pkg.sv
// Shared definitions for the four-requester round-robin arbiter.
// Holds the arbiter FSM state type plus requester count and index width.
package arb_pkg;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned IDW     = 2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage : arb_pkg

// File: rtl/prio_enc_4_2_v.sv
// Combinational 4:2 priority encoder, bit 3 highest priority.
// Ports:
//   din   - 4-bit request vector
//   idx   - binary index of the highest set bit (2'b00 when din is zero)
//   valid - high when any bit of din is set
module prio_enc_4_2_v
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] din,
    output logic [IDW-1:0]     idx,
    output logic               valid
);

    always_comb begin
        idx = '0;
        casez (din)
            4'b1???: idx = 2'd3;
            4'b01??: idx = 2'd2;
            4'b001?: idx = 2'd1;
            default: idx = 2'd0;
        endcase
    end

    assign valid = |din;

endmodule : prio_enc_4_2_v

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with grant hold and hold-time limit.
// Priority rotates behind the last owner; an owner keeps the grant while
// it holds its request, but is preempted after MAX_HOLD cycles when
// another client is waiting. Every owner change passes through one idle
// (all-zero grant) cycle. All outputs come straight from flops.
// Ports:
//   clk     - rising-edge clock
//   rst_n   - asynchronous active-low reset
//   req     - per-client request, held high while the resource is wanted
//   gnt     - one-hot grant
//   gnt_id  - binary index of the owner (2'b00 when no grant)
//   gnt_vld - high while any grant is active
//   preempt - one-cycle pulse when the grant is removed by the hold limit
module rr_arbiter_4
    import arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned CW       = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDW-1:0]     gnt_id,
    output logic               gnt_vld,
    output logic               preempt
);

    localparam logic [CW-1:0] HOLD_LIM = CW'(MAX_HOLD - 1);

    state_t             state, state_nxt;
    logic [CW-1:0]      cnt, cnt_nxt;
    logic [IDW-1:0]     last, last_nxt;
    logic [NUM_REQ-1:0] gnt_nxt;
    logic [IDW-1:0]     id_nxt;
    logic               preempt_nxt;

    logic [NUM_REQ-1:0] rot;
    logic [IDW-1:0]     enc_idx;
    logic               enc_vld;
    logic [IDW-1:0]     winner;

    // Rotate so the client just after the last owner sits on bit 3,
    // the encoder's highest-priority input.
    always_comb begin
        rot = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            rot[IDW'(NUM_REQ - 1 - k)] = req[last + IDW'(k + 1)];
        end
    end

    prio_enc_4_2_v u_enc (
        .din   (rot),
        .idx   (enc_idx),
        .valid (enc_vld)
    );

    // Undo the rotation; 2-bit arithmetic wraps modulo 4.
    assign winner = last + 2'd1 + (2'd3 - enc_idx);

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        last_nxt    = last;
        gnt_nxt     = gnt;
        id_nxt      = gnt_id;
        preempt_nxt = 1'b0;
        case (state)
            IDLE: begin
                gnt_nxt = '0;
                id_nxt  = '0;
                if (enc_vld) begin
                    state_nxt       = BUSY;
                    gnt_nxt[winner] = 1'b1;
                    id_nxt          = winner;
                    last_nxt        = winner;
                    cnt_nxt         = '0;
                end
            end
            BUSY: begin
                if (!req[gnt_id]) begin
                    // Voluntary release wins over a coincident hold limit.
                    state_nxt = IDLE;
                    gnt_nxt   = '0;
                    id_nxt    = '0;
                end else if (cnt == HOLD_LIM && |(req & ~gnt)) begin
                    state_nxt   = IDLE;
                    gnt_nxt     = '0;
                    id_nxt      = '0;
                    preempt_nxt = 1'b1;
                end else if (cnt != HOLD_LIM) begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
                id_nxt    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            last    <= 2'd3;
            gnt     <= '0;
            gnt_id  <= '0;
            gnt_vld <= 1'b0;
            preempt <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            last    <= last_nxt;
            gnt     <= gnt_nxt;
            gnt_id  <= id_nxt;
            gnt_vld <= |gnt_nxt;
            preempt <= preempt_nxt;
        end
    end

endmodule : rr_arbiter_4

// File: tb/tb_rr_arbiter_4.sv
// Scoreboard bench for rr_arbiter_4 (MAX_HOLD=4). Each stimulus step
// applies req at the falling edge and queues the outputs expected after
// the next rising edge; a monitor pops and compares every cycle.
module tb_rr_arbiter_4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0100;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_vld;
    logic       preempt;

    typedef struct packed {
        logic [3:0] g;
        logic [1:0] id;
        logic       vld;
        logic       pre;
    } obs_t;

    obs_t exp_q[$];
    int unsigned n_pass  = 0;
    int unsigned n_total = 0;
    int unsigned cyc     = 0;

    rr_arbiter_4 #(.MAX_HOLD(4), .CW(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .gnt_vld (gnt_vld),
        .preempt (preempt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input obs_t act, input obs_t exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got gnt=%b id=%0d vld=%b pre=%b, expected gnt=%b id=%0d vld=%b pre=%b",
                      name, act.g, act.id, act.vld, act.pre, exp.g, exp.id, exp.vld, exp.pre);
    endtask

    // Monitor: compare DUT outputs 1 time unit after each rising edge.
    initial begin
        obs_t e, a;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                a = '{g: gnt, id: gnt_id, vld: gnt_vld, pre: preempt};
                check($sformatf("cycle%0d", cyc), a, e);
            end
        end
    end

    task automatic step(input logic rst, input logic [3:0] r,
                        input logic [3:0] eg, input logic [1:0] eid, input logic ep);
        obs_t e;
        @(negedge clk);
        rst_n = rst;
        req   = r;
        e = '{g: eg, id: eid, vld: |eg, pre: ep};
        exp_q.push_back(e);
    endtask

    initial begin
        int owners[5] = '{0, 1, 2, 3, 0};
        logic [3:0] oh;
        logic [1:0] oid;
        obs_t zero_obs;
        zero_obs = '0;

        // Reset with a pending request, then single grant to client 2.
        step(1'b0, 4'b0100, 4'b0000, 2'd0, 1'b0);
        step(1'b0, 4'b0100, 4'b0000, 2'd0, 1'b0);
        step(1'b1, 4'b0100, 4'b0100, 2'd2, 1'b0);
        step(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0);
        step(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0);

        // Round-robin fairness from a fresh pointer: 0,1,2,3,0.
        step(1'b0, 4'b1111, 4'b0000, 2'd0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            oid = owners[i][1:0];
            oh  = 4'b0000;
            oh[oid] = 1'b1;
            for (int j = 0; j < 3; j++) step(1'b1, 4'b1111, oh, oid, 1'b0);
            step(1'b1, 4'b1111 & ~oh, 4'b0000, 2'd0, 1'b0);
        end

        // Preempt at MAX_HOLD=4 with req=0011 held.
        step(1'b0, 4'b0011, 4'b0000, 2'd0, 1'b0);
        for (int j = 0; j < 4; j++) step(1'b1, 4'b0011, 4'b0001, 2'd0, 1'b0);
        step(1'b1, 4'b0011, 4'b0000, 2'd0, 1'b1);
        for (int j = 0; j < 4; j++) step(1'b1, 4'b0011, 4'b0010, 2'd1, 1'b0);
        step(1'b1, 4'b0011, 4'b0000, 2'd0, 1'b1);
        step(1'b1, 4'b0011, 4'b0001, 2'd0, 1'b0);
        step(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0);
        step(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0);

        // Sole requester far beyond the limit, then a competitor appears.
        for (int j = 0; j < 40; j++) step(1'b1, 4'b1000, 4'b1000, 2'd3, 1'b0);
        step(1'b1, 4'b1001, 4'b0000, 2'd0, 1'b1);
        step(1'b1, 4'b1001, 4'b0001, 2'd0, 1'b0);

        // Release coinciding with the limit is a plain release.
        for (int j = 0; j < 3; j++) step(1'b1, 4'b1001, 4'b0001, 2'd0, 1'b0);
        step(1'b1, 4'b1000, 4'b0000, 2'd0, 1'b0);
        step(1'b1, 4'b1000, 4'b1000, 2'd3, 1'b0);
        step(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0);

        // Asynchronous reset while client 1 owns the grant.
        step(1'b1, 4'b0010, 4'b0010, 2'd1, 1'b0);
        step(1'b1, 4'b0010, 4'b0010, 2'd1, 1'b0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset", '{g: gnt, id: gnt_id, vld: gnt_vld, pre: preempt}, zero_obs);
        step(1'b0, 4'b1111, 4'b0000, 2'd0, 1'b0);
        step(1'b1, 4'b1111, 4'b0001, 2'd0, 1'b0);
        step(1'b1, 4'b1111, 4'b0001, 2'd0, 1'b0);

        // Let the monitor drain, bounded.
        for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_total++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_rr_arbiter_4

// File: doc/rr_arbiter_4.md
# rr_arbiter_4

Four-requester round-robin arbiter with grant hold and hold-time limit. It shares one downstream resource, such as a bus port or a shared datapath unit, between four clients. Grant selection uses a registered rotating-priority scheme built around a 4:2 priority encoder sub-module. The encoded grant index drives the resource mux select; the one-hot grant returns to the requesters.

## Interface
- MAX_HOLD, 16: maximum consecutive cycles one owner holds the grant while another request is pending (legal range 2..255).
- CW, 8: width of the hold counter; must satisfy 2^CW > MAX_HOLD.

- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous assert, active-low.
- req  input  4  request per client; the client holds it high for as long as it wants the resource.
- gnt  output  4  one-hot grant, registered.
- gnt_id  output  2  binary index of the current owner; valid only while gnt_vld=1, otherwise 2'b00.
- gnt_vld  output  1  high when any grant is active; equals |gnt.
- preempt  output  1  one-cycle pulse when the grant is removed because of MAX_HOLD.

## Operation
- States:
  - IDLE: no owner.
  - BUSY: one owner.
- Reset values: state=IDLE, gnt=4'b0000, gnt_id=2'b00, gnt_vld=0, preempt=0, hold counter=0, last pointer=2'd3.
  - With last=3 after reset, the first arbitration order is 0,1,2,3.
- Priority order from last pointer L: (L+1)%4 highest, then (L+2)%4, then (L+3)%4, with L lowest.
- IDLE behaviour:
  - If req≠0, grant the highest-priority requester. Next state BUSY. Load last=winner. Clear the counter.
  - If req=0, stay in IDLE; outputs stay 0.
- BUSY behaviour:
  - If req[owner]=0 (voluntary release): clear gnt, go to IDLE.
  - Else if counter==MAX_HOLD-1 and (req & ~gnt)≠0 (preempt): clear gnt, pulse preempt, go to IDLE.
  - Else stay in BUSY. The counter increments and saturates at MAX_HOLD-1.
  - If no other request is pending when the limit is reached, the owner keeps the grant indefinitely. A preempt fires as soon as another request appears.
- Every ownership change passes through IDLE, so gnt is all-zero for exactly one cycle between owners.
- A preempted owner still holding req is re-granted only after the other pending requesters, because last=owner.
- Changes on non-owner req bits while BUSY have no effect until the next IDLE cycle.
- Reset asserted mid-grant forces all outputs and state to reset values immediately. No grant survives reset.

## Timing
- Grant latency: req sampled in IDLE at edge n gives gnt high after edge n (visible cycle n+1). Minimum latency is 1 cycle.
- Release latency: req[owner] low sampled at edge n gives gnt=0 in cycle n+1. The next grant is earliest in cycle n+2.
- Preempt: gnt drops and preempt=1 in the same cycle, which is the cycle after the MAX_HOLD-th grant cycle. The owner therefore holds for exactly MAX_HOLD cycles.
- Simultaneous release and limit: treated as a voluntary release, so preempt=0.
- gnt, gnt_id, gnt_vld and preempt are all driven from flops; there is no combinational path from req to any output.

## Structure
- Shared package arb_pkg:
  - State enum {IDLE, BUSY}.
  - Constant NUM_REQ=4.
  - Width constant IDW=2.
- Sub-module prio_enc_4_2_v: combinational 4:2 encoder, bit 3 highest priority, with valid output (valid=|in).
- Top-level rotation around the encoder:
  - Rotate req so the highest-priority candidate lands on bit 3.
  - Encode.
  - Un-rotate the index: winner = (L+1 + (3 - enc)) % 4.
- Top level owns the FSM, hold counter, last pointer and output registers.

## Test plan
- Reset/single request: rst_n low with req=4'b0100; all outputs 0. Release reset, then the next cycle gives gnt=4'b0100, gnt_id=2, gnt_vld=1.
- Round-robin fairness: req=4'b1111 held, each owner releasing after 3 cycles and re-requesting. Grant sequence 0,1,2,3,0 with one zero-grant cycle between owners.
- Preempt: MAX_HOLD=4, req=4'b0011 held. gnt=4'b0001 for exactly 4 cycles, then gnt=0 with preempt=1, then gnt=4'b0010.
- Sole requester beyond limit: req=4'b1000 for 40 cycles. gnt stays 4'b1000 and preempt never fires. Raise req[0], and preempt fires the next cycle.
- Release and limit coincide: owner drops req in the MAX_HOLD-th cycle while another request is pending. gnt goes to 0 with preempt=0.
- Mid-grant reset: pulse rst_n low asynchronously while gnt=4'b0010. Outputs go to 0 immediately. After release with req=4'b1111, the first grant is to client 0.
